dice_cgra_tid_pipe: RTL and testbench

DICE_CGRA_TID_PIPE -- requirements
Module: dice_cgra_tid_pipe

---
 rtl/dice_cgra_pkg.sv | 6 +
 rtl/dice_tid_stage_mux.sv | 50 +++++
 rtl/dice_cgra_tid_pipe.sv | 106 ++++++++++
 tb/tb_dice_cgra_tid_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_cgra_pkg.sv
// dice_cgra_pkg: shared FSM state type and default sizing constants for the TID pipe
package dice_cgra_pkg;
  localparam int DEF_MAX_LATENCY = 32;
  localparam int DEF_TOTAL_TID = 512;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;
endpackage

// File: rtl/dice_tid_stage_mux.sv
// dice_tid_stage_mux: per-lane valid/TID shift chain with a latency-selected output tap
module dice_tid_stage_mux #(
  parameter int NUM_LANES = 1,
  parameter int TID_WIDTH = 9,
  parameter int MAX_LATENCY = 32,
  parameter int LAT_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           adv_i,
  input  logic [LAT_WIDTH-1:0]           lat_i,
  input  logic [NUM_LANES-1:0]           vld_i,
  input  logic [NUM_LANES*TID_WIDTH-1:0] tid_i,
  output logic [NUM_LANES-1:0]           tap_vld_o,
  output logic [NUM_LANES*TID_WIDTH-1:0] tap_tid_o
);
  logic [NUM_LANES-1:0]           v_q [MAX_LATENCY];
  logic [NUM_LANES*TID_WIDTH-1:0] t_q [MAX_LATENCY];
  // Shift on every non-stalled cycle; valids at or beyond the tap are dropped so a
  // retired entry can never resurface if the latency is later raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LATENCY; k++) begin
        v_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else if (clr_i) begin
      for (int k = 0; k < MAX_LATENCY; k++) v_q[k] <= '0;
    end else if (adv_i) begin
      v_q[0] <= (lat_i != '0) ? vld_i : '0;
      t_q[0] <= tid_i;
      for (int k = 1; k < MAX_LATENCY; k++) begin
        v_q[k] <= (LAT_WIDTH'(k) < lat_i) ? v_q[k-1] : '0;
        t_q[k] <= t_q[k-1];
      end
    end
  end
  // Tap stage lat-1; latency zero bypasses the chain entirely.
  always_comb begin
    tap_vld_o = (lat_i == '0) ? vld_i : '0;
    tap_tid_o = (lat_i == '0) ? tid_i : '0;
    for (int k = 0; k < MAX_LATENCY; k++) begin
      if (lat_i == LAT_WIDTH'(k + 1)) begin
        tap_vld_o = v_q[k];
        tap_tid_o = t_q[k];
      end
    end
  end
endmodule

// File: rtl/dice_cgra_tid_pipe.sv
// dice_cgra_tid_pipe: fixed-latency TID tracker for CGRA issue/retire with drain and flush control
module dice_cgra_tid_pipe
  import dice_cgra_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int TOTAL_TID = DEF_TOTAL_TID,
  parameter int TID_WIDTH = $clog2(TOTAL_TID),
  parameter int MAX_LATENCY = DEF_MAX_LATENCY,
  parameter int LAT_WIDTH = $clog2(MAX_LATENCY + 1),
  parameter int CNT_WIDTH = $clog2(MAX_LATENCY * NUM_LANES + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           stall,
  input  logic [LAT_WIDTH-1:0]           cfg_latency,
  input  logic                           flush_req,
  input  logic [NUM_LANES-1:0]           in_valid,
  input  logic [NUM_LANES*TID_WIDTH-1:0] in_tid,
  output logic                           in_ready,
  output logic [NUM_LANES-1:0]           out_valid,
  output logic [NUM_LANES*TID_WIDTH-1:0] out_tid,
  output logic                           empty,
  output logic [CNT_WIDTH-1:0]           inflight_cnt,
  output logic                           drain_done,
  output logic                           cfg_err
);
  state_e                         state_q, state_d;
  logic [LAT_WIDTH-1:0]           lat_q, lat_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic                           err_q, err_d;
  logic                           pend_q, pend_d;
  logic                           lat_load, too_big;
  logic [NUM_LANES-1:0]           acc, tap_vld;
  logic [NUM_LANES*TID_WIDTH-1:0] tap_tid;

  assign in_ready = rst_n & ~stall & ~clr & (state_q != DRAIN);
  assign acc = in_valid & {NUM_LANES{in_ready}};
  assign out_valid = tap_vld & {NUM_LANES{~stall & ~clr}};
  assign empty = (cnt_q == '0);
  assign inflight_cnt = cnt_q;
  assign cfg_err = err_q;
  assign drain_done = ((state_q == DRAIN) & empty & ~clr) | pend_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_tid
    assign out_tid[i*TID_WIDTH +: TID_WIDTH] = out_valid[i] ? tap_tid[i*TID_WIDTH +: TID_WIDTH] : '0;
  end

  dice_tid_stage_mux #(
    .NUM_LANES  (NUM_LANES),
    .TID_WIDTH  (TID_WIDTH),
    .MAX_LATENCY(MAX_LATENCY),
    .LAT_WIDTH  (LAT_WIDTH)
  ) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .adv_i    (~stall),
    .lat_i    (lat_q),
    .vld_i    (acc),
    .tid_i    (in_tid),
    .tap_vld_o(tap_vld),
    .tap_tid_o(tap_tid)
  );

  // Latency is only retargeted when nothing is in flight, so every live entry sees one tap.
  always_comb begin
    lat_load = empty & ~|acc;
    too_big = cfg_latency > LAT_WIDTH'(MAX_LATENCY);
    lat_d = lat_load ? (too_big ? LAT_WIDTH'(MAX_LATENCY) : cfg_latency) : lat_q;
    err_d = err_q | (lat_load & too_big);
    cnt_d = clr ? '0 : cnt_q + CNT_WIDTH'($countones(acc)) - CNT_WIDTH'($countones(out_valid));
    pend_d = clr & (state_q == DRAIN);
  end

  // Control FSM; a clear abandons any drain but its notification is still owed next cycle.
  always_comb begin
    state_d = state_q;
    if (clr) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = flush_req ? DRAIN : (|acc ? BUSY : IDLE);
        BUSY:    state_d = flush_req ? DRAIN : ((cnt_d == '0) ? IDLE : BUSY);
        DRAIN:   state_d = empty ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_dice_cgra_tid_pipe.sv
// tb_dice_cgra_tid_pipe: scoreboard bench for the CGRA TID pipe with directed scenarios
module tb_dice_cgra_tid_pipe;
  localparam int NL = 2;
  localparam int TW = 9;
  localparam int LW = 6;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          stall = 1'b0;
  logic          flush_req = 1'b0;
  logic [LW-1:0] cfg_latency = '0;
  logic [NL-1:0] in_valid = '0;
  logic [NL*TW-1:0] in_tid = '0;
  logic          in_ready, empty, drain_done, cfg_err;
  logic [NL-1:0] out_valid;
  logic [NL*TW-1:0] out_tid;
  logic [CW-1:0] inflight_cnt;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int c0;

  typedef struct {
    int c;
    logic [NL-1:0] v;
    logic [TW-1:0] t0;
    logic [TW-1:0] t1;
  } exp_t;
  exp_t sb[$];

  dice_cgra_tid_pipe #(.NUM_LANES(NL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .stall       (stall),
    .cfg_latency (cfg_latency),
    .flush_req   (flush_req),
    .in_valid    (in_valid),
    .in_tid      (in_tid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_tid     (out_tid),
    .empty       (empty),
    .inflight_cnt(inflight_cnt),
    .drain_done  (drain_done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(input logic [NL-1:0] v, input int t1, input int t0);
    in_valid = v;
    in_tid = {TW'(t1), TW'(t0)};
  endtask

  task automatic idle_in();
    in_valid = '0;
    in_tid = '0;
    flush_req = 1'b0;
  endtask

  task automatic push(input int c, input logic [NL-1:0] v, input int t1, input int t0);
    sb.push_back('{c, v, TW'(t0), TW'(t1)});
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid != '0) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got valid %b tid %h at cycle %0d, expected no retire", out_valid, out_tid, cyc);
      end else begin
        e = sb.pop_front();
        chk("retire_cycle", cyc, e.c);
        chk("out_valid", int'(out_valid), int'(e.v));
        if (e.v[0]) chk("tid_lane0", int'(out_tid[TW-1:0]), int'(e.t0));
        if (e.v[1]) chk("tid_lane1", int'(out_tid[2*TW-1:TW]), int'(e.t1));
      end
    end
  end

  initial begin
    issue(2'b11, 3, 4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_tid", int'(out_tid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_cnt", int'(inflight_cnt), 0);
    chk("rst_drain_done", int'(drain_done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    tick();
    idle_in();
    rst_n = 1'b1;
    // two lanes at latency 4
    cfg_latency = 4;
    tick();
    c0 = cyc;
    issue(2'b11, 6, 5);
    push(c0 + 4, 2'b11, 6, 5);
    tick();
    idle_in();
    for (int k = 1; k <= 3; k++) begin
      goto(c0 + k);
      @(negedge clk);
      chk("cnt_l4", int'(inflight_cnt), 2);
    end
    goto(c0 + 5);
    @(negedge clk);
    chk("cnt_l4_after", int'(inflight_cnt), 0);
    chk("empty_l4_after", int'(empty), 1);
    // stall before the tap at latency 3
    cfg_latency = 3;
    tick();
    c0 = cyc;
    issue(2'b01, 0, 7);
    push(c0 + 5, 2'b01, 0, 7);
    tick();
    idle_in();
    stall = 1'b1;
    @(negedge clk);
    chk("cnt_stalled", int'(inflight_cnt), 1);
    tick();
    tick();
    stall = 1'b0;
    goto(c0 + 7);
    // stall exactly on the retire cycle at latency 1
    cfg_latency = 1;
    tick();
    c0 = cyc;
    issue(2'b10, 8, 0);
    push(c0 + 2, 2'b10, 8, 0);
    tick();
    idle_in();
    stall = 1'b1;
    @(negedge clk);
    chk("stall_forces_zero", int'(out_valid), 0);
    tick();
    stall = 1'b0;
    goto(c0 + 4);
    // latency change while busy only takes effect once empty
    cfg_latency = 5;
    tick();
    c0 = cyc;
    issue(2'b01, 0, 10);
    push(c0 + 5, 2'b01, 0, 10);
    tick();
    idle_in();
    cfg_latency = 2;
    goto(c0 + 7);
    issue(2'b01, 0, 11);
    push(c0 + 9, 2'b01, 0, 11);
    tick();
    idle_in();
    goto(c0 + 11);
    // flush while busy at latency 8
    cfg_latency = 8;
    tick();
    c0 = cyc;
    issue(2'b11, 21, 20);
    push(c0 + 8, 2'b11, 21, 20);
    tick();
    issue(2'b01, 0, 22);
    flush_req = 1'b1;
    push(c0 + 9, 2'b01, 0, 22);
    @(negedge clk);
    chk("ready_before_drain", int'(in_ready), 1);
    tick();
    flush_req = 1'b0;
    issue(2'b01, 0, 99);
    for (int k = 2; k <= 9; k++) begin
      goto(c0 + k);
      @(negedge clk);
      chk("drain_ready", int'(in_ready), 0);
      chk("drain_done_early", int'(drain_done), 0);
    end
    goto(c0 + 10);
    idle_in();
    @(negedge clk);
    chk("drain_done_pulse", int'(drain_done), 1);
    chk("drain_empty", int'(empty), 1);
    tick();
    @(negedge clk);
    chk("drain_done_single", int'(drain_done), 0);
    chk("ready_after_drain", int'(in_ready), 1);
    // clear with six entries in flight and a drain pending
    tick();
    c0 = cyc;
    issue(2'b11, 31, 30);
    tick();
    issue(2'b11, 33, 32);
    tick();
    issue(2'b11, 35, 34);
    flush_req = 1'b1;
    tick();
    idle_in();
    clr = 1'b1;
    @(negedge clk);
    chk("cnt_before_clr", int'(inflight_cnt), 6);
    chk("drain_done_in_clr", int'(drain_done), 0);
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("drain_done_after_clr", int'(drain_done), 1);
    chk("empty_after_clr", int'(empty), 1);
    chk("cnt_after_clr", int'(inflight_cnt), 0);
    tick();
    @(negedge clk);
    chk("drain_done_after_clr_single", int'(drain_done), 0);
    chk("ready_after_clr", int'(in_ready), 1);
    goto(c0 + 14);
    // out-of-range latency clamps to 32
    cfg_latency = 40;
    tick();
    @(negedge clk);
    chk("cfg_err_set", int'(cfg_err), 1);
    c0 = cyc;
    issue(2'b10, 33, 0);
    push(c0 + 32, 2'b10, 33, 0);
    tick();
    idle_in();
    cfg_latency = 3;
    goto(c0 + 33);
    @(negedge clk);
    chk("cfg_err_sticky", int'(cfg_err), 1);
    chk("empty_after_clamp", int'(empty), 1);
    // zero latency passes straight through
    cfg_latency = 0;
    tick();
    c0 = cyc;
    issue(2'b01, 0, 9);
    push(c0, 2'b01, 0, 9);
    @(negedge clk);
    chk("cnt_l0_same", int'(inflight_cnt), 0);
    tick();
    idle_in();
    @(negedge clk);
    chk("cnt_l0_next", int'(inflight_cnt), 0);
    chk("empty_l0", int'(empty), 1);
    // flush while already empty
    goto(c0 + 3);
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush_empty_same", int'(drain_done), 0);
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    chk("flush_empty_next", int'(drain_done), 1);
    tick();
    @(negedge clk);
    chk("flush_empty_single", int'(drain_done), 0);
    // reset in the middle of operation discards in-flight TIDs
    cfg_latency = 4;
    tick();
    c0 = cyc;
    issue(2'b11, 40, 41);
    tick();
    idle_in();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_cfg_err", int'(cfg_err), 0);
    tick();
    rst_n = 1'b1;
    goto(c0 + 10);
    @(negedge clk);
    chk("post_rst_empty", int'(empty), 1);
    chk("post_rst_cnt", int'(inflight_cnt), 0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
